// File: rtl/k_fifo_wr_arb_t1.sv
// Round-robin burst arbiter sharing one FIFO write port among NREQ requesters.
// A grant lasts until the last beat, MAX_BURST beats or a dropped valid, then one IDLE cycle follows.
module k_fifo_wr_arb_t1 #(
    parameter  int NREQ      = 4,
    parameter  int data_size = 8,
    parameter  int MAX_BURST = 4,
    localparam int GW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ-1:0]           req_last,
    input  logic [NREQ*data_size-1:0] req_data,
    output logic [NREQ-1:0]           req_ready,
    output logic                      wput,
    output logic [data_size-1:0]      wdata,
    input  logic                      wrdy,
    output logic [GW-1:0]             grant_id,
    output logic                      busy
);

    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [GW-1:0] last_grant;
    logic [CW-1:0] beat_cnt;
    logic [GW-1:0] pick;
    logic          found;
    logic          beat;
    logic          rel;

    // Handshake: a beat moves when wput && wrdy; the granted requester keeps
    // valid/data/last stable until its req_ready bit pulses for that beat.
    assign beat = wput && wrdy;

    // Round-robin search starting one past the previous owner.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            if (!found && req_valid[(int'(last_grant) + i) % NREQ]) begin
                found = 1'b1;
                pick  = GW'((int'(last_grant) + i) % NREQ);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rel       = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (!req_valid[grant_id]) begin
                    rel = 1'b1;
                end else if (beat && (req_last[grant_id] ||
                                      beat_cnt == CW'(MAX_BURST - 1))) begin
                    rel = 1'b1;
                end
                if (rel) begin
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    always_comb begin
        busy      = (state == BUSY);
        wput      = !rst && (state == BUSY) && req_valid[grant_id];
        wdata     = req_data[int'(grant_id) * data_size +: data_size];
        req_ready = '0;
        if (beat) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    // Grant and beat count only move on arbitration or an accepted beat;
    // wrdy stalls leave both untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_id   <= '0;
            last_grant <= GW'(NREQ - 1);
            beat_cnt   <= '0;
        end else if (state == IDLE) begin
            if (found) begin
                grant_id <= pick;
                beat_cnt <= '0;
            end
        end else begin
            if (beat) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            if (rel) begin
                last_grant <= grant_id;
            end
        end
    end

endmodule

// File: tb/tb_k_fifo_wr_arb_t1.sv
// Directed bench for k_fifo_wr_arb_t1: reset, round-robin, early last, stall,
// valid drop and mid-burst reset, with a queue of expected FIFO writes.
module tb_k_fifo_wr_arb_t1;

    localparam int NREQ = 4;
    localparam int DW   = 8;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_last;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              wput;
    logic [DW-1:0]     wdata;
    logic              wrdy;
    logic [1:0]        grant_id;
    logic              busy;

    logic [DW-1:0] dat [NREQ] = '{8'h3C, 8'h4D, 8'h5E, 8'h6F};
    logic [DW-1:0] exp_q [$];
    int checks = 0;
    int errors = 0;

    k_fifo_wr_arb_t1 #(.NREQ(NREQ), .data_size(DW), .MAX_BURST(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wput      (wput),
        .wdata     (wdata),
        .wrdy      (wrdy),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks one cycle's outputs; an expected beat is queued for the monitor.
    task automatic exp_cycle(input string tag, input logic b, input logic [1:0] g,
                             input logic wp, input logic [3:0] rdy, input logic [DW-1:0] d);
        #1;
        chk({tag, "_busy"}, 32'(busy), 32'(b));
        chk({tag, "_grant"}, 32'(grant_id), 32'(g));
        chk({tag, "_wput"}, 32'(wput), 32'(wp));
        chk({tag, "_ready"}, 32'(req_ready), 32'(rdy));
        if (rdy != 4'b0) begin
            chk({tag, "_wdata"}, 32'(wdata), 32'(d));
            exp_q.push_back(d);
        end
    endtask

    // scoreboard: every FIFO write must match a queued expectation
    always @(negedge clk) begin
        if (wput && wrdy) begin
            if (exp_q.size() == 0) begin
                chk("extra_beat", 32'(wdata), 32'hFFFF_FFFF);
            end else begin
                chk("sb_beat", 32'(wdata), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        rst       = 1'b1;
        req_valid = 4'b1111;
        req_last  = 4'b0000;
        wrdy      = 1'b1;
        for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = dat[i];

        // reset held two cycles with every requester valid
        step(); exp_cycle("rst1", 1'b0, 2'd0, 1'b0, 4'b0000, 8'h00);
        step(); exp_cycle("rst2", 1'b0, 2'd0, 1'b0, 4'b0000, 8'h00);
        rst = 1'b0;

        // round robin 0,1,2,3,0: four beats then one IDLE cycle each
        step();
        for (int k = 0; k < 5; k++) begin
            for (int b = 0; b < 4; b++) begin
                exp_cycle("rr_beat", 1'b1, 2'(k % 4), 1'b1, 4'(1 << (k % 4)), dat[k % 4]);
                step();
            end
            if (k == 4) req_valid = 4'b0100;
            exp_cycle("rr_idle", 1'b0, 2'(k % 4), 1'b0, 4'b0000, 8'h00);
            step();
        end

        // early end: requester 2 flags last on its second beat
        exp_cycle("early_b1", 1'b1, 2'd2, 1'b1, 4'b0100, dat[2]);
        step(); req_last = 4'b0100;
        exp_cycle("early_b2", 1'b1, 2'd2, 1'b1, 4'b0100, dat[2]);
        step(); req_last = 4'b0000;
        exp_cycle("early_idle", 1'b0, 2'd2, 1'b0, 4'b0000, 8'h00);
        step();
        exp_cycle("regrant2", 1'b1, 2'd2, 1'b1, 4'b0100, dat[2]);

        // stall five cycles after the first beat; burst still totals four beats
        step(); wrdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            exp_cycle("stall", 1'b1, 2'd2, 1'b1, 4'b0000, 8'h00);
            step();
        end
        wrdy = 1'b1;
        exp_cycle("stall_b2", 1'b1, 2'd2, 1'b1, 4'b0100, dat[2]);
        step(); exp_cycle("stall_b3", 1'b1, 2'd2, 1'b1, 4'b0100, dat[2]);
        step(); exp_cycle("stall_b4", 1'b1, 2'd2, 1'b1, 4'b0100, dat[2]);
        step(); req_valid = 4'b1010;
        exp_cycle("stall_idle", 1'b0, 2'd2, 1'b0, 4'b0000, 8'h00);

        // valid drop: requester 3 wins from last_grant=2, drops after one beat
        step(); exp_cycle("drop_b1", 1'b1, 2'd3, 1'b1, 4'b1000, dat[3]);
        step(); req_valid = 4'b0010;
        exp_cycle("drop_rel", 1'b1, 2'd3, 1'b0, 4'b0000, 8'h00);
        step(); exp_cycle("drop_idle", 1'b0, 2'd3, 1'b0, 4'b0000, 8'h00);
        step(); exp_cycle("drop_next", 1'b1, 2'd1, 1'b1, 4'b0010, dat[1]);

        // reset on the second beat of requester 1's burst
        step(); rst = 1'b1;
        exp_cycle("mrst_hold", 1'b1, 2'd1, 1'b0, 4'b0000, 8'h00);
        step(); rst = 1'b0;
        exp_cycle("mrst_idle", 1'b0, 2'd0, 1'b0, 4'b0000, 8'h00);
        step(); req_last = 4'b0010;
        exp_cycle("mrst_regrant", 1'b1, 2'd1, 1'b1, 4'b0010, dat[1]);
        step(); req_last = 4'b0000; req_valid = 4'b0000;
        exp_cycle("quiet1", 1'b0, 2'd1, 1'b0, 4'b0000, 8'h00);
        step(); exp_cycle("quiet2", 1'b0, 2'd1, 1'b0, 4'b0000, 8'h00);

        step();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
